// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: runs T1..T4 memory cycles (with TW wait states) for
// either EU data accesses or instruction prefetch into a small byte queue.
module bus_cycle_ctrl #(
    parameter int QUEUE_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Direction,
    input  logic        req,
    input  logic        req_wr,
    input  logic [7:0]  wr_data,
    input  logic        Ready,
    input  logic [7:0]  Bus_In,
    input  logic        q_pop,
    input  logic        flush,
    output logic [19:0] Addr_Out,
    output logic        ALE,
    output logic        RD_n,
    output logic        WR_n,
    output logic [7:0]  Bus_Out,
    output logic        Bus_OE,
    output logic        Q_EN,
    output logic [7:0]  Q_Data,
    output logic        IP_INC,
    output logic        ack,
    output logic [7:0]  rd_data,
    output logic [2:0]  q_count,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

    localparam logic [2:0] QMAX = 3'(QUEUE_BYTES);

    state_t     state;
    state_t     next_state;
    logic       start_eu;
    logic       is_eu;
    logic       is_wr;
    logic       flush_flag;
    logic [7:0] wr_latch;
    logic [2:0] next_count;
    logic       strobe_next;
    logic       write_next;
    logic       push_next;
    logic       eu_done_next;

    // Queue occupancy after this cycle's push/pop/flush; flush wins, a
    // simultaneous push and pop cancel, and pops on an empty queue are ignored.
    always_comb begin
        next_count = q_count;
        if (flush) begin
            next_count = 3'd0;
        end else if (Q_EN && !q_pop) begin
            if (q_count < QMAX) begin
                next_count = q_count + 3'd1;
            end
        end else if (!Q_EN && q_pop && (q_count != 3'd0)) begin
            next_count = q_count - 3'd1;
        end
    end

    // Next bus state; a new cycle may only be launched from IDLE or T4, with
    // EU requests taking priority over prefetch.
    always_comb begin
        next_state = state;
        start_eu   = 1'b0;
        case (state)
            IDLE, T4: begin
                if (req) begin
                    next_state = T1;
                    start_eu   = 1'b1;
                end else if ((next_count < QMAX) && !flush) begin
                    next_state = T1;
                end else begin
                    next_state = IDLE;
                end
            end
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3, TW:  next_state = Ready ? T4 : TW;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the state being entered, so every output is registered.
    always_comb begin
        strobe_next  = (next_state == T2) || (next_state == T3) || (next_state == TW);
        write_next   = strobe_next && is_wr;
        push_next    = (next_state == T4) && !is_eu && !flush_flag && !flush;
        eu_done_next = (next_state == T4) && is_eu;
    end

    // State register plus all registered outputs and per-cycle latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            is_eu      <= 1'b0;
            is_wr      <= 1'b0;
            flush_flag <= 1'b0;
            wr_latch   <= 8'h00;
            Addr_Out   <= 20'h00000;
            ALE        <= 1'b0;
            RD_n       <= 1'b1;
            WR_n       <= 1'b1;
            Bus_Out    <= 8'h00;
            Bus_OE     <= 1'b0;
            Q_EN       <= 1'b0;
            Q_Data     <= 8'h00;
            IP_INC     <= 1'b0;
            ack        <= 1'b0;
            rd_data    <= 8'h00;
            q_count    <= 3'd0;
            busy       <= 1'b0;
        end else begin
            state   <= next_state;
            q_count <= next_count;
            if (next_state == T1) begin
                Addr_Out <= Direction;
                is_eu    <= start_eu;
                is_wr    <= start_eu && req_wr;
                wr_latch <= wr_data;
            end
            if (state == T4) begin
                flush_flag <= 1'b0;
            end else if (flush && !is_eu && (state != IDLE)) begin
                flush_flag <= 1'b1;
            end
            ALE     <= (next_state == T1);
            RD_n    <= !(strobe_next && !is_wr);
            WR_n    <= !write_next;
            Bus_OE  <= write_next;
            Bus_Out <= write_next ? wr_latch : 8'h00;
            Q_EN    <= push_next;
            IP_INC  <= push_next;
            if (push_next) begin
                Q_Data <= Bus_In;
            end
            ack <= eu_done_next;
            if (eu_done_next && !is_wr) begin
                rd_data <= Bus_In;
            end
            busy <= (next_state != IDLE);
        end
    end

endmodule
